noc_inport_handshake_adapter: RTL and testbench
===============================================

Name: noc_inport_handshake_adapter

Overview:
Transmit-side companion of the NoC ejection adapter. Converts a standard valid/ready stream (e.g. Xilinx native FIFO read side or an AXI-Stream-like producer) into the NoC avail/valid injection handshake toward a router local input port. Buffers up to two flits internally so the upstream `ready_o` never depends combinationally on `avail_i`. Guarantees that at most two flits are driven with valid after `avail_i` is deasserted, matching the 2-entry absorb window of NoC receivers.

Parameters:
- DataWidth, 64, flit width in bits; must be >= 1.
- BufDepth, 2, internal buffer entries; fixed at 2, and other values are unsupported.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- data_i  input  DataWidth  upstream flit.
- data_valid_i  input  1  upstream flit valid.
- ready_o  output  1  block can accept `data_i` this cycle.
- data_o  output  DataWidth  flit toward the NoC local input port.
- data_valid_o  output  1  flit valid toward the NoC; each high cycle is exactly one flit.
- avail_i  input  1  NoC router can accept flits.

Behaviour:
- Reset, while `rst`=1 and on the following edge:
  - `data_valid_o`=0, `data_o`=0, `ready_o`=0.
  - count=0, rd/wr pointers=0, avail_q=0.
  - Buffer contents are don't-care and discarded.
  - Reset mid-transfer drops all buffered flits; no partial flit is emitted.
- avail_q: register, avail_q <= `avail_i` every cycle (one-cycle sample).
- ready_o = !rst && (count < 2). It is a function of registers only, with no combinational path from `avail_i` or `data_valid_i`.
- Push: `data_valid_i` && `ready_o` writes `data_i` at wr pointer; wr pointer toggles.
- Launch (pop) at each edge:
  - If avail_q==1 && count>0: `data_valid_o` <= 1, `data_o` <= buf[rd], rd pointer toggles.
  - Else: `data_valid_o` <= 0, and `data_o` holds its previous value.
- count update:
  - count += push − pop.
  - Push and pop in the same cycle leaves count unchanged; this is legal only when count==1.
  - count==2 blocks push; count==0 blocks pop.
  - There is no same-cycle bypass from `data_i` to `data_o`.
- Latency: a flit accepted in cycle T appears on `data_valid_o`/`data_o` no earlier than cycle T+2 (min latency 2).
- Throughput: 1 flit/cycle sustained while `avail_i`=1 and upstream supplies every cycle (count steady at 1).
- Ordering: strict FIFO; no flit is duplicated or dropped outside reset.
- Avail deassert: if `avail_i` falls in cycle T, `data_valid_o` may be high in T and T+1 only. It is 0 from T+2 until `avail_i` returns.
- Avail reassert: if `avail_i` rises in cycle R and count>0, `data_valid_o` is high in R+2.
- No retransmit: NoC receivers must absorb the flits sent during the 2-cycle window.
- `avail_i` toggling every cycle: each launch uses the registered sample only; the two-flit bound still holds.
- `data_valid_i` high while `ready_o`=0: the flit is not taken. Upstream holds it per valid/ready rules.

Decomposition:
- Shared NoC adapter package holds:
  - localparam ADAPTER_BUF_DEPTH=2.
  - localparam AVAIL_DEASSERT_WINDOW=2, the maximum valids after avail drop, shared with the ejection adapter and assertions.
- One natural sub-module: noc_adapter_fifo2, a 2-entry register FIFO with push/pop/count/head.
  - The top level keeps avail_q, the launch logic and the output register.

Test Plan:
1. Reset release: hold `rst` 3 cycles with `data_valid_i`=1 → `ready_o`=0, `data_valid_o`=0 and `data_o`=0 throughout. `ready_o`=1 in the first cycle after `rst` drops.
2. Streaming: `avail_i`=1, push 0x01..0x10 (DataWidth=8) on consecutive cycles from cycle 5 → `data_o` shows 0x01..0x10 on consecutive cycles from cycle 7, with no gaps. `ready_o` stays 1.
3. Backpressure: stream with `avail_i` dropped at cycle 10 → at most 2 valid flits in cycles 10–11 and `data_valid_o`=0 from cycle 12. `ready_o`=0 once 2 flits are buffered. After `avail_i`=1 at cycle 20, the buffered flits emerge in order from cycle 22.
4. Buffer full: `avail_i`=0, push 0xA1 and 0xA2 → `ready_o`=0. 0xA3 stays held by upstream. Raise `avail_i` → out 0xA1, 0xA2, 0xA3 in order.
5. Random: random `avail_i` and `data_valid_i`, 10k cycles → scoreboard shows an in-order, lossless sequence. Assertion: valid count after each avail fall ≤2.
6. Mid-operation reset: 2 flits buffered with `avail_i`=0, assert `rst` 1 cycle, then `avail_i`=1 → no stale flit on `data_valid_o`. The next pushed 0x55 is the first flit out.

Source files
------------

// File: rtl/noc_adapter_pkg.sv
// noc_adapter_pkg: constants shared by the NoC injection and ejection adapters
package noc_adapter_pkg;
    localparam int ADAPTER_BUF_DEPTH = 2;
    localparam int AVAIL_DEASSERT_WINDOW = 2;
    typedef logic [1:0] fifo_count_t;
endpackage

// File: rtl/noc_adapter_fifo2.sv
// noc_adapter_fifo2: two-entry register FIFO with push/pop, occupancy count and head
module noc_adapter_fifo2
    import noc_adapter_pkg::*;
#(
    parameter int DataWidth = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DataWidth-1:0] wdata,
    output logic [DataWidth-1:0] head,
    output fifo_count_t          count
);
    logic [DataWidth-1:0] mem [ADAPTER_BUF_DEPTH];
    logic wr;
    logic rd;

    // storage is not reset; the count alone decides which entries are live
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= wdata;
    end

    // pointers toggle between the two entries; count tracks push minus pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr    <= 1'b0;
            rd    <= 1'b0;
            count <= '0;
        end else begin
            if (push) wr <= ~wr;
            if (pop) rd <= ~rd;
            count <= count + fifo_count_t'(push) - fifo_count_t'(pop);
        end
    end

    assign head = mem[rd];
endmodule

// File: rtl/noc_inport_handshake_adapter.sv
// noc_inport_handshake_adapter: valid/ready stream to NoC avail/valid injection port
module noc_inport_handshake_adapter
    import noc_adapter_pkg::*;
#(
    parameter int DataWidth = 64,
    parameter int BufDepth  = ADAPTER_BUF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 data_valid_i,
    output logic                 ready_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 data_valid_o,
    input  logic                 avail_i
);
    logic                 avail_q;
    logic                 push;
    logic                 pop;
    logic [DataWidth-1:0] head;
    fifo_count_t          count;

    assign ready_o = !rst && (count < fifo_count_t'(BufDepth));
    assign push    = data_valid_i && ready_o;
    assign pop     = avail_q && (count != '0);

    noc_adapter_fifo2 #(.DataWidth(DataWidth)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (data_i),
        .head  (head),
        .count (count)
    );

    // launch only on the registered avail sample, bounding valids after avail drops to two
    always_ff @(posedge clk) begin
        if (rst) begin
            avail_q      <= 1'b0;
            data_valid_o <= 1'b0;
            data_o       <= '0;
        end else begin
            avail_q      <= avail_i;
            data_valid_o <= pop;
            if (pop) data_o <= head;
        end
    end
endmodule

// File: tb/tb_noc_inport_handshake_adapter.sv
// tb_noc_inport_handshake_adapter: directed and scoreboarded checks of the injection adapter
module tb_noc_inport_handshake_adapter;
    import noc_adapter_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] data_i;
    logic       data_valid_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       avail_i;

    int errors = 0;
    int checks = 0;

    noc_inport_handshake_adapter #(.DataWidth(8), .BufDepth(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .avail_i      (avail_i)
    );

    initial clk = 1'b0;
    // free-running clock, period 10
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [16:0] bp_rdy = 17'b11111_0000000_11111;
    logic [16:0] bp_dv  = 17'b01111_0000000_11100;
    logic [7:0]  bp_d [17] = '{8'h00, 8'h00, 8'h21, 8'h22, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h24, 8'h25, 8'h26, 8'h27, 8'h00};
    logic [7:0]  q [$];
    logic [7:0]  v;
    logic [7:0]  pv;
    logic        pend;
    logic        av1;
    logic        av2;
    int          fall_cnt;

    task automatic sb_check;
        if (data_valid_o) begin
            if (q.size() == 0) chk("sb_spurious", 1, 0);
            else chk("sb_data", data_o, q.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1;
        data_valid_i = 1'b1;
        data_i = 8'h77;
        avail_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            #1;
            chk("rst_ready", ready_o, 0);
            chk("rst_dv", data_valid_o, 0);
            chk("rst_data", data_o, 0);
        end
        step;
        rst = 1'b0;
        data_valid_i = 1'b0;
        #1;
        chk("post_rst_ready", ready_o, 1);
        chk("post_rst_dv", data_valid_o, 0);

        for (int i = 0; i < 19; i++) begin
            step;
            data_valid_i = (i < 16);
            data_i = 8'(i + 1);
            #1;
            chk("stream_ready", ready_o, 1);
            chk("stream_dv", data_valid_o, (i >= 2 && i < 18));
            if (i >= 2 && i < 18) chk("stream_data", data_o, i - 1);
        end

        v = 8'h21;
        for (int c = 0; c < 17; c++) begin
            step;
            avail_i = !(c >= 3 && c < 10);
            data_valid_i = (c <= 13);
            data_i = v;
            #1;
            chk("bp_ready", ready_o, bp_rdy[c]);
            chk("bp_dv", data_valid_o, bp_dv[c]);
            if (bp_dv[c]) chk("bp_data", data_o, bp_d[c]);
            if (data_valid_i && ready_o) v = v + 8'd1;
        end

        step; avail_i = 1'b0; data_valid_i = 1'b1; data_i = 8'hA1; #1;
        chk("full_a0_ready", ready_o, 1);
        chk("full_a0_dv", data_valid_o, 0);
        step; data_i = 8'hA2; #1;
        chk("full_a1_ready", ready_o, 1);
        step; data_i = 8'hA3; #1;
        chk("full_a2_ready", ready_o, 0);
        chk("full_a2_dv", data_valid_o, 0);
        step; avail_i = 1'b1; #1;
        chk("full_a3_ready", ready_o, 0);
        step; #1;
        chk("full_a4_ready", ready_o, 0);
        chk("full_a4_dv", data_valid_o, 0);
        step; #1;
        chk("full_a5_dv", data_valid_o, 1);
        chk("full_a5_data", data_o, 8'hA1);
        chk("full_a5_ready", ready_o, 1);
        step; data_valid_i = 1'b0; #1;
        chk("full_a6_dv", data_valid_o, 1);
        chk("full_a6_data", data_o, 8'hA2);
        step; #1;
        chk("full_a7_dv", data_valid_o, 1);
        chk("full_a7_data", data_o, 8'hA3);
        step; #1;
        chk("full_a8_dv", data_valid_o, 0);

        pend = 1'b0;
        pv = 8'h00;
        av1 = 1'b1;
        av2 = 1'b1;
        fall_cnt = 0;
        for (int k = 0; k < 10000; k++) begin
            step;
            if (!pend) begin
                pend = ($urandom_range(0, 1) == 1);
                pv = 8'($urandom);
            end
            data_valid_i = pend;
            data_i = pv;
            avail_i = (k < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            #1;
            sb_check;
            if (!av1 && !av2) chk("win_idle", data_valid_o, 0);
            fall_cnt = avail_i ? 0 : fall_cnt + int'(data_valid_o);
            if (!avail_i) chk("win_cnt", fall_cnt <= AVAIL_DEASSERT_WINDOW, 1);
            if (data_valid_i && ready_o) begin
                q.push_back(data_i);
                pend = 1'b0;
            end
            av2 = av1;
            av1 = avail_i;
        end
        for (int k = 0; k < 6; k++) begin
            step;
            data_valid_i = 1'b0;
            avail_i = 1'b1;
            #1;
            sb_check;
        end
        chk("sb_drained", q.size(), 0);

        step; avail_i = 1'b0; data_valid_i = 1'b1; data_i = 8'h61; #1;
        chk("mrst_m0_ready", ready_o, 1);
        step; data_i = 8'h62; #1;
        chk("mrst_m1_ready", ready_o, 1);
        step; data_valid_i = 1'b0; rst = 1'b1; #1;
        chk("mrst_ready", ready_o, 0);
        chk("mrst_dv", data_valid_o, 0);
        step; rst = 1'b0; avail_i = 1'b1; data_valid_i = 1'b1; data_i = 8'h55; #1;
        chk("mrst_r1_ready", ready_o, 1);
        chk("mrst_r1_dv", data_valid_o, 0);
        chk("mrst_r1_data", data_o, 0);
        step; data_valid_i = 1'b0; #1;
        chk("mrst_r2_dv", data_valid_o, 0);
        step; #1;
        chk("mrst_r3_dv", data_valid_o, 1);
        chk("mrst_r3_data", data_o, 8'h55);
        step; #1;
        chk("mrst_r4_dv", data_valid_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
